// File: rtl/vc_mem_responder_pkg.sv
// Message layouts, stall FSM states and byte-lane helpers for the VC memory responder.
// Pure declarations and functions; no latency and no flow control of its own.
// Imported by the responder top and by anything packing requests for it.
package vc_mem_responder_pkg;

    localparam int REQ_W  = 67;
    localparam int RESP_W = 35;

    typedef enum logic {
        MSG_READ  = 1'b0,
        MSG_WRITE = 1'b1
    } msg_type_e;

    // {type, addr, len, data}; field order matches the request bit layout
    typedef struct packed {
        msg_type_e   typ;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } req_msg_t;

    typedef struct packed {
        msg_type_e   typ;
        logic [1:0]  len;
        logic [31:0] data;
    } resp_msg_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } stall_state_e;

    // len==0 encodes a full word
    function automatic int byte_count(input logic [1:0] len);
        return (len == 2'd0) ? 4 : int'(len);
    endfunction

    // Lanes offset..offset+n-1, clipped at lane 3 so a write never spills into the next word
    function automatic logic [3:0] write_strobe(input logic [1:0] off, input logic [1:0] len);
        logic [3:0] be;
        int         k;
        be = '0;
        for (int b = 0; b < 4; b++) begin
            k = b - int'(off);
            if (k >= 0 && k < byte_count(len)) be[b] = 1'b1;
        end
        return be;
    endfunction

    // Right-align the addressed bytes; lanes past byte 3 shift in as zero, upper bytes masked
    function automatic logic [31:0] read_align(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] len);
        logic [31:0] shifted;
        logic [31:0] mask;
        shifted = word >> {off, 3'b000};
        case (len)
            2'd1:    mask = 32'h0000_00FF;
            2'd2:    mask = 32'h0000_FFFF;
            2'd3:    mask = 32'h00FF_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        return shifted & mask;
    endfunction

endpackage

// File: rtl/vc_mem_resp_delay_pipe.sv
// Fixed-length shift register of {val, resp_msg}; only the valid bits are cleared by reset.
// Latency: exactly LAT cycles from in_dat to out_dat.
// No backpressure: one entry enters and one leaves every cycle, so it can never overflow.
module vc_mem_resp_delay_pipe #(
    parameter int LAT = 1,
    parameter int W   = 36
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_dat,
    output logic [W-1:0] out_dat
);

    logic [LAT-1:0] vld_q;
    logic [W-2:0]   dat_q [LAT];
    logic [W-2:0]   out_msg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_dat[W-1];
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Payload only moves with its valid bit, so idle-cycle X on the input never lands here
    always_ff @(posedge clk) begin
        if (in_dat[W-1]) dat_q[0] <= in_dat[W-2:0];
        for (int i = 1; i < LAT; i++) begin
            if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
        end
    end

    assign out_msg = vld_q[LAT-1] ? dat_q[LAT-1] : '0;
    assign out_dat = {vld_q[LAT-1], out_msg};

endmodule

// File: rtl/vc_mem_responder.sv
// Single-port byte-granular memory answering VC memory requests on a val/rdy port.
// Latency: response valid LAT cycles after acceptance, in acceptance order.
// Backpressure: req_rdy drops one cycle after every STALL_PERIOD accepts; responses are val-only.
module vc_mem_responder
    import vc_mem_responder_pkg::*;
#(
    parameter int MEM_WORDS    = 1024,
    parameter int LAT          = 1,
    parameter int STALL_PERIOD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REQ_W-1:0]  req_msg,
    input  logic              req_val,
    output logic              req_rdy,
    output logic [RESP_W-1:0] resp_msg,
    output logic              resp_val
);

    localparam int  IDX_W    = $clog2(MEM_WORDS);
    localparam int  CNT_W    = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam bit  STALL_EN = (STALL_PERIOD > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (STALL_PERIOD > 1) ? CNT_W'(STALL_PERIOD - 1) : '0;

    logic [31:0] mem [0:MEM_WORDS-1];

    req_msg_t         req;
    resp_msg_t        resp_d;
    logic             accept;
    logic             wr_en;
    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic [3:0]       wr_be;
    logic [31:0]      wr_word;
    logic [31:0]      rd_word;

    stall_state_e     state_q;
    stall_state_e     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [RESP_W:0]  pipe_in;
    logic [RESP_W:0]  pipe_out;

    assign req    = req_msg_t'(req_msg);
    assign accept = req_val & req_rdy;
    // Address bits above the array depth are ignored so the index wraps
    assign idx    = req.addr[IDX_W+1:2];
    assign off    = req.addr[1:0];

    // ------------------------------------------------------------------
    // Array: writes commit at the accept edge, reads see the pre-edge word
    // ------------------------------------------------------------------
    assign wr_en   = accept && (req.typ == MSG_WRITE);
    assign wr_be   = write_strobe(off, req.len);
    assign wr_word = req.data << {off, 3'b000};
    assign rd_word = mem[idx];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    always_comb begin
        resp_d.typ  = req.typ;
        resp_d.len  = req.len;
        resp_d.data = (req.typ == MSG_WRITE) ? 32'h0 : read_align(rd_word, off, req.len);
    end

    // ------------------------------------------------------------------
    // Stall FSM: one dead cycle after every STALL_PERIOD accepts
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (STALL_EN && accept) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_STALL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_STALL: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Gated by reset directly so rdy is low throughout reset and high as soon as it releases
    assign req_rdy = reset && (state_q == ST_RUN);

    // ------------------------------------------------------------------
    // Response latency pipe
    // ------------------------------------------------------------------
    assign pipe_in = {accept, resp_d};

    vc_mem_resp_delay_pipe #(
        .LAT (LAT),
        .W   (RESP_W + 1)
    ) u_delay (
        .clk     (clk),
        .reset   (reset),
        .in_dat  (pipe_in),
        .out_dat (pipe_out)
    );

    assign resp_val = pipe_out[RESP_W];
    assign resp_msg = pipe_out[RESP_W-1:0];

endmodule

// File: tb/tb_vc_mem_responder.sv
// Directed bench for vc_mem_responder: three instances cover LAT=1, LAT=3 and STALL_PERIOD=2.
module tb_vc_mem_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // a: LAT=1, b: LAT=3, s: LAT=1 with STALL_PERIOD=2
    logic [66:0] a_msg, b_msg, s_msg;
    logic        a_val, b_val, s_val;
    logic        a_rdy, b_rdy, s_rdy;
    logic [34:0] a_resp, b_resp, s_resp;
    logic        a_rval, b_rval, s_rval;

    int n_cmp = 0;
    int n_bad = 0;

    vc_mem_responder #(.MEM_WORDS(1024), .LAT(1), .STALL_PERIOD(0)) dut (
        .clk(clk), .reset(reset), .req_msg(a_msg), .req_val(a_val), .req_rdy(a_rdy),
        .resp_msg(a_resp), .resp_val(a_rval));

    vc_mem_responder #(.MEM_WORDS(1024), .LAT(3), .STALL_PERIOD(0)) dut3 (
        .clk(clk), .reset(reset), .req_msg(b_msg), .req_val(b_val), .req_rdy(b_rdy),
        .resp_msg(b_resp), .resp_val(b_rval));

    vc_mem_responder #(.MEM_WORDS(1024), .LAT(1), .STALL_PERIOD(2)) dut_s (
        .clk(clk), .reset(reset), .req_msg(s_msg), .req_val(s_val), .req_rdy(s_rdy),
        .resp_msg(s_resp), .resp_val(s_rval));

    function automatic logic [66:0] mk_req(input logic typ, input logic [31:0] addr,
                                           input logic [1:0] len, input logic [31:0] data);
        return {typ, addr, len, data};
    endfunction

    function automatic logic [34:0] mk_resp(input logic typ, input logic [1:0] len,
                                            input logic [31:0] data);
        return {typ, len, data};
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({a_rdy, b_rdy, s_rdy} !== 3'b000) begin
            n_bad++; $display("FAIL reset_rdy: got %b expected 000", {a_rdy, b_rdy, s_rdy});
        end
        n_cmp++;
        if ({a_rval, b_rval, s_rval} !== 3'b000 || a_resp !== 35'h0) begin
            n_bad++; $display("FAIL reset_resp: got val %b msg %h expected 000 / 0",
                              {a_rval, b_rval, s_rval}, a_resp);
        end
        @(posedge clk); #2 reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({a_rdy, b_rdy, s_rdy} !== 3'b111) begin
            n_bad++; $display("FAIL release_rdy: got %b expected 111", {a_rdy, b_rdy, s_rdy});
        end
        // put one read in flight on the LAT=3 instance, then reset before it emerges
        @(posedge clk); #1 b_val = 1'b1; b_msg = mk_req(1'b0, 32'h0, 2'd0, 32'h0);
        @(posedge clk); #1 b_val = 1'b0;
        @(negedge clk); #1 reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (b_rval !== 1'b0) begin
                n_bad++; $display("FAIL midreset_val[%0d]: got %b expected 0", c, b_rval);
            end
        end
        @(posedge clk); #2 reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({b_rdy, b_rval} !== 2'b10) begin
                n_bad++; $display("FAIL postreset[%0d]: got rdy,val %b expected 10", c, {b_rdy, b_rval});
            end
        end
    endtask

    task automatic test_write_read();
        logic [66:0] req [2];
        logic [34:0] exp [2];
        req[0] = mk_req(1'b1, 32'h10, 2'd0, 32'hDEADBEEF); exp[0] = mk_resp(1'b1, 2'd0, 32'h0);
        req[1] = mk_req(1'b0, 32'h10, 2'd0, 32'h0);       exp[1] = mk_resp(1'b0, 2'd0, 32'hDEADBEEF);
        for (int c = 0; c <= 2; c++) begin
            @(posedge clk); #1;
            a_val = (c < 2);
            a_msg = (c < 2) ? req[c] : 'x;
            @(negedge clk);
            n_cmp++;
            if (c == 0) begin
                if (a_rval !== 1'b0) begin
                    n_bad++; $display("FAIL wr_rd_idle: got val %b expected 0", a_rval);
                end
            end else if ({a_rval, a_resp} !== {1'b1, exp[c-1]}) begin
                n_bad++; $display("FAIL wr_rd[%0d]: got %b/%h expected 1/%h", c-1, a_rval, a_resp, exp[c-1]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (a_rval !== 1'b0) begin
            n_bad++; $display("FAIL wr_rd_drain: got val %b expected 0", a_rval);
        end
    endtask

    task automatic test_subword();
        logic [66:0] req [5];
        logic [34:0] exp [5];
        req[0] = mk_req(1'b1, 32'h13, 2'd1, 32'h000000AA); exp[0] = mk_resp(1'b1, 2'd1, 32'h0);
        req[1] = mk_req(1'b0, 32'h10, 2'd0, 32'h0);        exp[1] = mk_resp(1'b0, 2'd0, 32'hAAADBEEF);
        req[2] = mk_req(1'b0, 32'h12, 2'd2, 32'h0);        exp[2] = mk_resp(1'b0, 2'd2, 32'h0000AAAD);
        req[3] = mk_req(1'b0, 32'h13, 2'd2, 32'h0);        exp[3] = mk_resp(1'b0, 2'd2, 32'h000000AA);
        req[4] = mk_req(1'b0, 32'h11, 2'd3, 32'h0);        exp[4] = mk_resp(1'b0, 2'd3, 32'h00AAADBE);
        for (int c = 0; c <= 5; c++) begin
            @(posedge clk); #1;
            a_val = (c < 5);
            a_msg = (c < 5) ? req[c] : 'x;
            @(negedge clk);
            if (c > 0) begin
                n_cmp++;
                if ({a_rval, a_resp} !== {1'b1, exp[c-1]}) begin
                    n_bad++; $display("FAIL subword[%0d]: got %b/%h expected 1/%h", c-1, a_rval, a_resp, exp[c-1]);
                end
            end
        end
        @(negedge clk);
        n_cmp++;
        if (a_rval !== 1'b0) begin
            n_bad++; $display("FAIL subword_drain: got val %b expected 0", a_rval);
        end
    endtask

    task automatic test_wrap();
        logic [66:0] req [3];
        logic [34:0] exp [3];
        req[0] = mk_req(1'b1, 32'h1000, 2'd0, 32'h12345678); exp[0] = mk_resp(1'b1, 2'd0, 32'h0);
        req[1] = mk_req(1'b0, 32'h0000, 2'd0, 32'h0);        exp[1] = mk_resp(1'b0, 2'd0, 32'h12345678);
        req[2] = mk_req(1'b0, 32'h2000, 2'd1, 32'h0);        exp[2] = mk_resp(1'b0, 2'd1, 32'h00000078);
        for (int c = 0; c <= 3; c++) begin
            @(posedge clk); #1;
            a_val = (c < 3);
            a_msg = (c < 3) ? req[c] : 'x;
            @(negedge clk);
            if (c > 0) begin
                n_cmp++;
                if ({a_rval, a_resp} !== {1'b1, exp[c-1]}) begin
                    n_bad++; $display("FAIL wrap[%0d]: got %b/%h expected 1/%h", c-1, a_rval, a_resp, exp[c-1]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [66:0] req [16];
        logic [34:0] exp [16];
        for (int i = 0; i < 8; i++) begin
            req[i]   = mk_req(1'b1, 32'h40 + 32'(4*i), 2'd0, 32'hC0DE0000 + 32'(i));
            exp[i]   = mk_resp(1'b1, 2'd0, 32'h0);
            req[i+8] = mk_req(1'b0, 32'h40 + 32'(4*i), 2'd0, 32'h0);
            exp[i+8] = mk_resp(1'b0, 2'd0, 32'hC0DE0000 + 32'(i));
        end
        for (int c = 0; c < 16 + 4; c++) begin
            @(posedge clk); #1;
            b_val = (c < 16);
            b_msg = (c < 16) ? req[c] : 'x;
            @(negedge clk);
            n_cmp++;
            if (c >= 3 && c - 3 < 16) begin
                if ({b_rval, b_resp} !== {1'b1, exp[c-3]}) begin
                    n_bad++; $display("FAIL b2b[%0d]: got %b/%h expected 1/%h", c-3, b_rval, b_resp, exp[c-3]);
                end
            end else if (b_rval !== 1'b0) begin
                n_bad++; $display("FAIL b2b_idle[c=%0d]: got val %b expected 0", c, b_rval);
            end
        end
    endtask

    task automatic test_stall();
        logic [66:0] req [6];
        logic [34:0] exp [6];
        logic [7:0]  pat;
        int          idx;
        int          prev_idx;
        int          nresp;
        bit          prev_acc;
        req[0] = mk_req(1'b1, 32'h0, 2'd0, 32'h11111111); exp[0] = mk_resp(1'b1, 2'd0, 32'h0);
        req[1] = mk_req(1'b0, 32'h0, 2'd0, 32'h0);        exp[1] = mk_resp(1'b0, 2'd0, 32'h11111111);
        req[2] = mk_req(1'b1, 32'h4, 2'd0, 32'h22222222); exp[2] = mk_resp(1'b1, 2'd0, 32'h0);
        req[3] = mk_req(1'b0, 32'h4, 2'd1, 32'h0);        exp[3] = mk_resp(1'b0, 2'd1, 32'h00000022);
        req[4] = mk_req(1'b1, 32'h9, 2'd2, 32'h00003333); exp[4] = mk_resp(1'b1, 2'd2, 32'h0);
        req[5] = mk_req(1'b0, 32'h9, 2'd2, 32'h0);        exp[5] = mk_resp(1'b0, 2'd2, 32'h00003333);
        pat = 8'b11011011;  // bit c = expected req_rdy in cycle c
        idx = 0; prev_idx = 0; nresp = 0; prev_acc = 1'b0;
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            s_val = (idx < 6);
            s_msg = (idx < 6) ? req[idx] : 'x;
            @(negedge clk);
            n_cmp++;
            if (prev_acc) begin
                if ({s_rval, s_resp} !== {1'b1, exp[prev_idx]}) begin
                    n_bad++; $display("FAIL stall_resp[%0d]: got %b/%h expected 1/%h", prev_idx, s_rval, s_resp, exp[prev_idx]);
                end
            end else if (s_rval !== 1'b0) begin
                n_bad++; $display("FAIL stall_idle[c=%0d]: got val %b expected 0", c, s_rval);
            end
            if (s_rval === 1'b1) nresp++;
            if (c < 8) begin
                n_cmp++;
                if (s_rdy !== pat[c]) begin
                    n_bad++; $display("FAIL stall_rdy[c=%0d]: got %b expected %b", c, s_rdy, pat[c]);
                end
            end
            prev_acc = s_val && s_rdy;
            prev_idx = idx;
            if (prev_acc) idx++;
        end
        n_cmp++;
        if (nresp !== 6 || idx !== 6) begin
            n_bad++; $display("FAIL stall_count: got %0d responses / %0d accepts expected 6 / 6", nresp, idx);
        end
    endtask

    initial begin
        a_val = 1'b0; b_val = 1'b0; s_val = 1'b0;
        a_msg = '0;   b_msg = '0;   s_msg = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        test_reset();
        test_write_read();
        test_subword();
        test_wrap();
        test_back_to_back();
        test_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
